// File: rtl/i2c_pkg.sv
// i2c_pkg: shared I2C constants, frontend FSM and slave controller state encodings
package i2c_pkg;
  localparam int I2C_BYTE_BITS = 8;
  localparam logic I2C_ACK = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  typedef enum logic [1:0] {FE_IDLE, FE_SHIFT, FE_ACK} fe_state_t;
  typedef enum logic [2:0] {SL_IDLE, SL_ADDR, SL_ADDR_ACK, SL_RX, SL_RX_ACK, SL_TX, SL_TX_ACK} sl_state_t;
endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: synchroniser, glitch filter and registered edge pulses for one bus line
module i2c_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic f,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(FILTER_CYCLES + 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  logic f_d;
  logic s;
  logic hit;
  assign s = sync[SYNC_STAGES-1];
  assign hit = (s != f) && (cnt == CW'(FILTER_CYCLES - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync <= '1;
      f <= 1'b1;
      f_d <= 1'b1;
      cnt <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], line};
      cnt <= (s == f || hit) ? '0 : cnt + 1'b1;
      f <= hit ? s : f;
      f_d <= f;
      rise <= f & ~f_d;
      fall <= ~f & f_d;
    end
endmodule

// File: rtl/i2c_bus_frontend.sv
// i2c_bus_frontend: filtered SCL/SDA, START/STOP detection and 9-bit frame deserialiser
module i2c_bus_frontend import i2c_pkg::*; #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_f,
  output logic       sda_f,
  output logic       scl_rise,
  output logic       scl_fall,
  output logic       start_det,
  output logic       stop_det,
  output logic       bus_busy,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_is_addr,
  output logic       ack_valid,
  output logic       ack_bit,
  output logic       framing_err
);
  logic sda_rise, sda_fall, scl_prev, scl_hi2;
  fe_state_t state, state_n;
  logic [3:0] bit_cnt, cnt_n;
  logic first, first_n;
  logic [I2C_BYTE_BITS-1:0] sh, sh_n, data_n;
  logic bv_n, ia_n, av_n, ack_n;
  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)) u_scl (
    .clk(clk), .rst(rst), .line(scl_in), .f(scl_f), .rise(scl_rise), .fall(scl_fall)
  );
  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)) u_sda (
    .clk(clk), .rst(rst), .line(sda_in), .f(sda_f), .rise(sda_rise), .fall(sda_fall)
  );
  // scl_hi2 is SCL high across the cycle SDA changed and the one before, aligned with the SDA pulses
  assign start_det = sda_fall & scl_hi2;
  assign stop_det = sda_rise & scl_hi2;
  assign framing_err = (start_det | stop_det) &
                       ((state == FE_SHIFT && bit_cnt != 4'd0) || state == FE_ACK);
  always_comb begin
    state_n = state;
    cnt_n = bit_cnt;
    first_n = first;
    sh_n = sh;
    data_n = byte_data;
    bv_n = 1'b0;
    ia_n = 1'b0;
    av_n = 1'b0;
    ack_n = ack_bit;
    if (start_det) begin
      state_n = FE_SHIFT;
      cnt_n = 4'd0;
      first_n = 1'b1;
    end else if (stop_det) begin
      state_n = FE_IDLE;
    end else if (scl_rise && state == FE_SHIFT) begin
      sh_n = {sh[I2C_BYTE_BITS-2:0], sda_f};
      cnt_n = bit_cnt + 4'd1;
      if (bit_cnt == 4'(I2C_BYTE_BITS - 1)) begin
        data_n = sh_n;
        bv_n = 1'b1;
        ia_n = first;
        state_n = FE_ACK;
      end
    end else if (scl_rise && state == FE_ACK) begin
      ack_n = sda_f;
      av_n = 1'b1;
      first_n = 1'b0;
      cnt_n = 4'd0;
      state_n = FE_SHIFT;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= FE_IDLE;
      bit_cnt <= 4'd0;
      first <= 1'b0;
      sh <= '0;
      byte_data <= '0;
      byte_valid <= 1'b0;
      byte_is_addr <= 1'b0;
      ack_valid <= 1'b0;
      ack_bit <= 1'b0;
      bus_busy <= 1'b0;
      scl_prev <= 1'b1;
      scl_hi2 <= 1'b0;
    end else begin
      state <= state_n;
      bit_cnt <= cnt_n;
      first <= first_n;
      sh <= sh_n;
      byte_data <= data_n;
      byte_valid <= bv_n;
      byte_is_addr <= ia_n;
      ack_valid <= av_n;
      ack_bit <= ack_n;
      bus_busy <= start_det ? 1'b1 : stop_det ? 1'b0 : bus_busy;
      scl_prev <= scl_f;
      scl_hi2 <= scl_f & scl_prev;
    end
endmodule

// File: tb/tb_i2c_bus_frontend.sv
// tb_i2c_bus_frontend: bit-level I2C master with transaction model and scoreboard monitor
module tb_i2c_bus_frontend;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_in = 1'b1;
  logic sda_in = 1'b1;
  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, bus_busy;
  logic byte_valid, byte_is_addr, ack_valid, ack_bit, framing_err;
  logic [7:0] byte_data;
  int checks = 0;
  int failures = 0;
  bit done = 1'b0;
  logic [14:0] exp_q[$];
  logic [2:0] lvl_q[$];
  logic [14:0] act, e;
  logic [2:0] lvl;
  bit m_active = 1'b0;
  bit m_first = 1'b0;
  bit m_busy = 1'b0;
  int m_pos = 0;
  logic [7:0] m_sh = 8'h00;

  always #5 clk = ~clk;

  i2c_bus_frontend #(.SYNC_STAGES(2), .FILTER_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in),
    .scl_f(scl_f), .sda_f(sda_f), .scl_rise(scl_rise), .scl_fall(scl_fall),
    .start_det(start_det), .stop_det(stop_det), .bus_busy(bus_busy),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_is_addr(byte_is_addr),
    .ack_valid(ack_valid), .ack_bit(ack_bit), .framing_err(framing_err)
  );

  function automatic logic [14:0] ev(input logic st, sp, fe, bv, ia, input logic [7:0] d,
                                     input logic av, ak);
    return {st, sp, fe, bv, ia, d, av, ak};
  endfunction

  // Monitor: pops a pulse-event expectation whenever the DUT emits any pulse,
  // and one level expectation per cycle while any are queued.
  always @(negedge clk) begin
    if (!rst && (start_det || stop_det || byte_valid || ack_valid || framing_err)) begin
      act = ev(start_det, stop_det, framing_err, byte_valid, byte_valid & byte_is_addr,
               byte_valid ? byte_data : 8'h00, ack_valid, ack_valid & ack_bit);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event t=%0t got=%h (st sp fe bv ia data av ak) none expected", $time, act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          failures++;
          $display("FAIL event t=%0t got=%h expected=%h", $time, act, e);
        end
      end
    end
    if (lvl_q.size() != 0) begin
      lvl = lvl_q.pop_front();
      checks++;
      if ({scl_f, sda_f, bus_busy} !== lvl) begin
        failures++;
        $display("FAIL levels t=%0t scl_f/sda_f/bus_busy got=%b expected=%b", $time,
                 {scl_f, sda_f, bus_busy}, lvl);
      end
    end
    if (done) begin
      checks++;
      if (exp_q.size() != 0 || lvl_q.size() != 0) begin
        failures++;
        $display("FAIL drain pending_events=%0d pending_levels=%0d expected=0", exp_q.size(), lvl_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  task automatic wt(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int rt();
    return int'($urandom_range(14, 7));
  endfunction

  task automatic model_bit(input logic b);
    if (m_active) begin
      m_pos++;
      if (m_pos <= 8) m_sh = {m_sh[6:0], b};
      if (m_pos == 8) exp_q.push_back(ev(0, 0, 0, 1, m_first, m_sh, 0, 0));
      if (m_pos == 9) begin
        exp_q.push_back(ev(0, 0, 0, 0, 0, 8'h00, 1, b));
        m_pos = 0;
        m_first = 1'b0;
      end
    end
  endtask

  task automatic model_start();
    exp_q.push_back(ev(1, 0, m_active && m_pos != 0, 0, 0, 8'h00, 0, 0));
    m_active = 1'b1;
    m_pos = 0;
    m_first = 1'b1;
    m_busy = 1'b1;
  endtask

  task automatic model_stop();
    exp_q.push_back(ev(0, 1, m_active && m_pos != 0, 0, 0, 8'h00, 0, 0));
    m_active = 1'b0;
    m_busy = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    sda_in = b;
    wt(rt());
    scl_in = 1'b1;
    model_bit(b);
    wt(rt());
    scl_in = 1'b0;
    wt(rt());
  endtask

  task automatic send_byte(input logic [7:0] d, input logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(ack);
    lvl_q.push_back({1'b0, ack, m_busy});
  endtask

  // A START issued while SCL is low first raises SCL, which the frontend counts as a bit.
  task automatic do_start();
    if (!scl_in) begin
      sda_in = 1'b1;
      wt(rt());
      scl_in = 1'b1;
      model_bit(1'b1);
      wt(rt());
    end
    sda_in = 1'b0;
    model_start();
    wt(rt());
    scl_in = 1'b0;
    wt(rt());
    lvl_q.push_back(3'b001);
  endtask

  task automatic do_stop();
    if (!scl_in) begin
      sda_in = 1'b0;
      wt(rt());
      scl_in = 1'b1;
      model_bit(1'b0);
      wt(rt());
    end
    sda_in = 1'b1;
    model_stop();
    wt(rt() + 4);
    lvl_q.push_back(3'b110);
  endtask

  task automatic idle_levels(input int n);
    repeat (n) begin
      lvl_q.push_back(3'b110);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] d;
    wt(5);
    rst = 1'b0;
    idle_levels(100);
    do_start();
    send_byte(8'hA0, 1'b0);
    do_stop();
    wt(20);
    do_start();
    send_byte(8'hA0, 1'b0);
    send_byte(8'h3C, 1'b0);
    send_byte(8'hFF, 1'b1);
    do_stop();
    wt(20);
    for (int k = 0; k < 2; k++) begin
      sda_in = 1'b0;
      repeat (3) begin
        lvl_q.push_back(3'b110);
        @(negedge clk);
      end
      sda_in = 1'b1;
      idle_levels(12);
    end
    sda_in = 1'b0;
    model_start();
    wt(4);
    sda_in = 1'b1;
    model_stop();
    wt(20);
    lvl_q.push_back(3'b110);
    wt(5);
    do_start();
    send_byte(8'hA0, 1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    do_start();
    send_byte(8'hA1, 1'b0);
    do_stop();
    wt(20);
    do_start();
    d = 8'($urandom);
    for (int i = 7; i >= 3; i--) send_bit(d[i]);
    wt(20);
    rst = 1'b1;
    scl_in = 1'b1;
    sda_in = 1'b1;
    m_active = 1'b0;
    m_busy = 1'b0;
    m_pos = 0;
    wt(5);
    rst = 1'b0;
    idle_levels(20);
    do_start();
    send_byte(8'h42, 1'b0);
    wt(30);
    for (int t = 0; t < 4; t++) begin
      do_start();
      for (int b = 0; b < int'($urandom_range(3, 1)); b++)
        send_byte(8'($urandom), 1'($urandom));
      do_stop();
      wt(rt());
    end
    wt(30);
    done = 1'b1;
    wt(5);
    $display("FAIL bench did not reach summary");
    $fatal(1);
  end
endmodule
